// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer
// Multi-cycle unsigned multiply/divide controller that borrows the processor's
// N-bit ALU. MULU runs shift-add; DIVU runs restoring subtract-shift. Each
// operation takes N iteration cycles plus one done cycle. Divide-by-zero
// completes immediately without touching the ALU.
module alu_muldiv_sequencer #(
  parameter int         N      = 4,
  parameter logic [3:0] OP_ADD = 4'b0010
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic         op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] result_lo_o,
  output logic [N-1:0] result_hi_o,
  output logic         div_zero_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic         alu_c_o,
  output logic         alu_invert_o,
  output logic [3:0]   alu_op_o,
  input  logic [N-1:0] alu_result_i,
  input  logic         alu_c_i
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  opnd_q, opnd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  res_lo_q, res_lo_d;
  logic [N-1:0]  res_hi_q, res_hi_d;
  logic          dz_q, dz_d;

  // Iteration helpers. The multiply sum is the ALU's N+1 bit result; the
  // divide step works on the partial remainder shifted left by one, where the
  // bit shifted out of acc (ov) means the shifted value already exceeds opnd.
  logic [N:0]   mul_sum;
  logic [N-1:0] div_sh;
  logic         div_ov;
  logic         div_take;
  logic         last_iter;

  assign mul_sum   = {alu_c_i, alu_result_i};
  assign div_sh    = {acc_q[N-2:0], q_q[N-1]};
  assign div_ov    = acc_q[N-1];
  assign div_take  = div_ov | alu_c_i;
  assign last_iter = (cnt_q == LAST_ITER);

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign result_lo_o = res_lo_q;
  assign result_hi_o = res_hi_q;
  assign div_zero_o  = dz_q;
  assign alu_op_o    = OP_ADD;

  // ALU operand steering, driven only from state and registers
  always_comb begin
    alu_a_o      = '0;
    alu_b_o      = '0;
    alu_c_o      = 1'b0;
    alu_invert_o = 1'b0;
    case (state_q)
      S_MUL: begin
        alu_a_o = acc_q;
        alu_b_o = q_q[0] ? opnd_q : '0;
      end
      S_DIV: begin
        alu_a_o      = div_sh;
        alu_b_o      = opnd_q;
        alu_c_o      = 1'b1;
        alu_invert_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    q_d      = q_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d  = '0;
          q_d    = a_i;
          opnd_d = b_i;
          cnt_d  = '0;
          if (!op_i) begin
            state_d = S_MUL;
          end else if (b_i != '0) begin
            state_d = S_DIV;
          end else begin
            // Divide by zero completes at accept; the ALU is never used.
            state_d  = S_DONE;
            res_lo_d = '1;
            res_hi_d = a_i;
            dz_d     = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_sum[N:1];
        q_d   = {mul_sum[0], q_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d  = S_DONE;
          res_hi_d = mul_sum[N:1];
          res_lo_d = {mul_sum[0], q_q[N-1:1]};
          dz_d     = 1'b0;
        end
      end
      S_DIV: begin
        acc_d = div_take ? alu_result_i : div_sh;
        q_d   = {q_q[N-2:0], div_take};
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d  = S_DONE;
          res_hi_d = div_take ? alu_result_i : div_sh;
          res_lo_d = {q_q[N-2:0], div_take};
          dz_d     = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      q_q      <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// tb_alu_muldiv_sequencer
// Directed bench: N = 8 sequencer attached to a behavioural N-bit adder ALU.
module tb_alu_muldiv_sequencer;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] res_lo;
  logic [N-1:0] res_hi;
  logic         div_zero;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_c;
  logic         alu_inv;
  logic [3:0]   alu_op;
  logic [N-1:0] alu_res;
  logic         alu_cout;

  int checks   = 0;
  int failures = 0;

  alu_muldiv_sequencer #(.N(N), .OP_ADD(4'b0010)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .op_i         (op),
    .a_i          (a),
    .b_i          (b),
    .busy_o       (busy),
    .done_o       (done),
    .result_lo_o  (res_lo),
    .result_hi_o  (res_hi),
    .div_zero_o   (div_zero),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_c_o      (alu_c),
    .alu_invert_o (alu_inv),
    .alu_op_o     (alu_op),
    .alu_result_i (alu_res),
    .alu_c_i      (alu_cout)
  );

  // Behavioural ALU: a + (invert ? ~b : b) + carry-in
  logic [N:0] alu_sum;
  always_comb begin
    alu_sum  = {1'b0, alu_a} + {1'b0, (alu_inv ? ~alu_b : alu_b)} + {{N{1'b0}}, alu_c};
    alu_res  = alu_sum[N-1:0];
    alu_cout = alu_sum[N];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sampling and driving happen 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full operation from accept in cycle 0 to done in cycle N+1, ending in cycle N+2
  task automatic run_op(input string tag, input logic o, input logic [N-1:0] av,
                        input logic [N-1:0] bv, input logic [N-1:0] exp_lo,
                        input logic [N-1:0] exp_hi);
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0;
    for (int i = 1; i < N + 1; i++) tick();
    check({tag, "_done"}, 16'(done), 16'd1);
    check({tag, "_lo"}, 16'(res_lo), 16'(exp_lo));
    check({tag, "_hi"}, 16'(res_hi), 16'(exp_hi));
    check({tag, "_dz"}, 16'(div_zero), 16'd0);
    $display("txn %s op=%0d a=0x%0h b=0x%0h lo=0x%0h hi=0x%0h", tag, o, av, bv, res_lo, res_hi);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #1;
    tick(); tick();

    // Reset state
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_lo", 16'(res_lo), 16'd0);
    check("rst_hi", 16'(res_hi), 16'd0);
    check("rst_dz", 16'(div_zero), 16'd0);
    check("rst_alu_a", 16'(alu_a), 16'd0);
    check("rst_alu_inv", 16'(alu_inv), 16'd0);
    rst_n = 1'b1;
    tick();

    // 1. MULU 13 x 11 with cycle-accurate busy/done
    start = 1'b1; op = 1'b0; a = 8'd13; b = 8'd11;
    check("t1_c0_busy", 16'(busy), 16'd0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= N; c++) begin
      check($sformatf("t1_c%0d_busy", c), 16'(busy), 16'd1);
      check($sformatf("t1_c%0d_done", c), 16'(done), 16'd0);
      check($sformatf("t1_c%0d_op", c), 16'(alu_op), 16'h2);
      tick();
    end
    check("t1_c9_done", 16'(done), 16'd1);
    check("t1_c9_busy", 16'(busy), 16'd1);
    check("t1_lo", 16'(res_lo), 16'h8F);
    check("t1_hi", 16'(res_hi), 16'h00);
    $display("txn t1 MULU 13x11 lo=0x%0h hi=0x%0h", res_lo, res_hi);
    tick();
    check("t1_c10_busy", 16'(busy), 16'd0);
    check("t1_c10_done", 16'(done), 16'd0);
    check("t1_hold_lo", 16'(res_lo), 16'h8F);

    // 2. Multiply boundaries
    run_op("t2_ffxff", 1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE);
    run_op("t2_0x5a", 1'b0, 8'h00, 8'h5A, 8'h00, 8'h00);

    // 3. Divides, with an invert check on the first iteration
    start = 1'b1; op = 1'b1; a = 8'd200; b = 8'd7;
    tick();
    start = 1'b0;
    check("t3_div_inv", 16'(alu_inv), 16'd1);
    check("t3_div_cin", 16'(alu_c), 16'd1);
    for (int i = 2; i < N + 2; i++) tick();
    check("t3_200_7_done", 16'(done), 16'd1);
    check("t3_200_7_lo", 16'(res_lo), 16'h1C);
    check("t3_200_7_hi", 16'(res_hi), 16'h04);
    check("t3_200_7_dz", 16'(div_zero), 16'd0);
    $display("txn t3 DIVU 200/7 lo=0x%0h hi=0x%0h", res_lo, res_hi);
    tick();
    run_op("t3_ff_80", 1'b1, 8'hFF, 8'h80, 8'h01, 8'h7F);
    run_op("t3_5_9", 1'b1, 8'd5, 8'd9, 8'h00, 8'h05);

    // 4. Divide by zero
    start = 1'b1; op = 1'b1; a = 8'd9; b = 8'd0;
    tick();
    start = 1'b0;
    check("t4_done", 16'(done), 16'd1);
    check("t4_busy", 16'(busy), 16'd1);
    check("t4_lo", 16'(res_lo), 16'hFF);
    check("t4_hi", 16'(res_hi), 16'h09);
    check("t4_dz", 16'(div_zero), 16'd1);
    check("t4_inv", 16'(alu_inv), 16'd0);
    $display("txn t4 DIVU 9/0 lo=0x%0h hi=0x%0h dz=%0d", res_lo, res_hi, div_zero);
    tick();
    check("t4_c2_busy", 16'(busy), 16'd0);
    check("t4_c2_done", 16'(done), 16'd0);
    check("t4_dz_hold", 16'(div_zero), 16'd1);

    // 5. Ignored start mid-operation, then start held high for back-to-back
    start = 1'b1; op = 1'b0; a = 8'd3; b = 8'd5;
    tick();                                   // cycle 1
    start = 1'b0;
    tick(); tick(); tick();                   // cycle 4
    start = 1'b1; op = 1'b1; a = 8'hAA; b = 8'h55;
    tick();                                   // cycle 5
    start = 1'b0;
    check("t5_c5_inv", 16'(alu_inv), 16'd0);
    tick(); tick(); tick();                   // cycle 8
    check("t5_c8_done", 16'(done), 16'd0);
    start = 1'b1; op = 1'b0; a = 8'd7; b = 8'd9;
    tick();                                   // cycle 9
    check("t5_c9_done", 16'(done), 16'd1);
    check("t5_lo", 16'(res_lo), 16'h0F);
    check("t5_hi", 16'(res_hi), 16'h00);
    check("t5_dz_clear", 16'(div_zero), 16'd0);
    $display("txn t5 MULU 3x5 lo=0x%0h hi=0x%0h", res_lo, res_hi);
    tick();                                   // cycle 10
    check("t5_c10_busy", 16'(busy), 16'd0);
    tick();                                   // cycle 11
    start = 1'b0;
    check("t5_c11_busy", 16'(busy), 16'd1);
    for (int i = 0; i < N; i++) tick();       // cycle 19
    check("t5_b2b_done", 16'(done), 16'd1);
    check("t5_b2b_lo", 16'(res_lo), 16'h3F);
    check("t5_b2b_hi", 16'(res_hi), 16'h00);
    $display("txn t5 MULU 7x9 lo=0x%0h hi=0x%0h", res_lo, res_hi);
    tick();

    // 6. Reset in cycle 5 of a divide
    start = 1'b1; op = 1'b1; a = 8'd200; b = 8'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();           // cycle 5
    rst_n = 1'b0;
    tick();                                   // cycle 6
    rst_n = 1'b1;
    check("t6_busy", 16'(busy), 16'd0);
    check("t6_lo", 16'(res_lo), 16'd0);
    check("t6_hi", 16'(res_hi), 16'd0);
    check("t6_alu_inv", 16'(alu_inv), 16'd0);
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < N + 4; i++) begin
        if (done) seen_done++;
        tick();
      end
      check("t6_no_done", 16'(seen_done), 16'd0);
    end
    $display("txn t6 reset mid-DIVU busy=%0d lo=0x%0h", busy, res_lo);
    run_op("t6_2x3", 1'b0, 8'd2, 8'd3, 8'h06, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
